// File: rtl/vend_sequencer.sv
// Actuator sequencer: runs the soda motor, then pays change one nickel at a time with a hopper handshake.
// Optional sales/nickel counters are enabled by defining VEND_SEQ_COUNT_EN.
module vend_sequencer #(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        soda_i,
    input  logic [2:0]  change_i,
    input  logic        clear_i,
    input  logic        motor_done_i,
    input  logic        eject_ack_i,
    output logic        motor_o,
    output logic        eject_o,
    output logic        busy_o,
    output logic        fault_o,
    output logic        dropped_o,
    output logic [2:0]  coins_left_o,
    output logic [15:0] sales_cnt_o,
    output logic [15:0] nickels_out_o
);

    localparam int unsigned TW = 16;
    localparam int unsigned CW = 3;
    localparam int unsigned NW = 16;
    localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VEND     = 3'd1,
        EJECT    = 3'd2,
        WAIT_ACK = 3'd3,
        FAULT    = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   coins_q, coins_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            motor_q, motor_d;
    logic            eject_q, eject_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;
    logic            dropped_q, dropped_d;

    // State, owed-coin and timer registers plus registered Moore outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            coins_q   <= '0;
            timer_q   <= '0;
            motor_q   <= 1'b0;
            eject_q   <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            coins_q   <= coins_d;
            timer_q   <= timer_d;
            motor_q   <= motor_d;
            eject_q   <= eject_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
            dropped_q <= dropped_d;
        end
    end

    // Next-state, owed-coin and output decode; responses win over a same-cycle timeout
    always_comb begin
        state_d   = state_q;
        coins_d   = coins_q;
        timer_d   = '0;
        dropped_d = soda_i && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (soda_i) begin
                    coins_d = change_i;
                    state_d = VEND;
                end
            end
            VEND: begin
                if (motor_done_i) begin
                    state_d = (coins_q == '0) ? IDLE : EJECT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = FAULT;
                end
            end
            EJECT: begin
                if (timer_q == PULSE_LAST) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (eject_ack_i) begin
                    coins_d = coins_q - CW'(1);
                    state_d = (coins_q == CW'(1)) ? IDLE : EJECT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (clear_i) begin
                    coins_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                coins_d = '0;
                state_d = IDLE;
            end
        endcase

        // Timer restarts on every state entry and only runs in timed states
        if ((state_d == state_q) &&
            ((state_q == VEND) || (state_q == EJECT) || (state_q == WAIT_ACK))) begin
            timer_d = timer_q + TW'(1);
        end

        motor_d = (state_d == VEND);
        eject_d = (state_d == EJECT);
        busy_d  = (state_d != IDLE);
        fault_d = (state_d == FAULT);
    end

    assign motor_o      = motor_q;
    assign eject_o      = eject_q;
    assign busy_o       = busy_q;
    assign fault_o      = fault_q;
    assign dropped_o    = dropped_q;
    assign coins_left_o = coins_q;

`ifdef VEND_SEQ_COUNT_EN
    logic [NW-1:0] sales_q;
    logic [NW-1:0] nickels_q;
    logic          sale_c;
    logic          ack_c;

    assign sale_c = (state_q == VEND) && motor_done_i;
    assign ack_c  = (state_q == WAIT_ACK) && eject_ack_i;

    // Saturating activity counters, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sales_q   <= '0;
            nickels_q <= '0;
        end else begin
            if (sale_c && (sales_q != '1)) begin
                sales_q <= sales_q + NW'(1);
            end
            if (ack_c && (nickels_q != '1)) begin
                nickels_q <= nickels_q + NW'(1);
            end
        end
    end

    assign sales_cnt_o   = sales_q;
    assign nickels_out_o = nickels_q;
`else
    assign sales_cnt_o   = '0;
    assign nickels_out_o = '0;
`endif

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer (PULSE_CYCLES=4, TIMEOUT_CYCLES=10).
module tb_vend_sequencer;

`ifdef VEND_SEQ_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        soda_i = 1'b0;
    logic [2:0]  change_i = 3'd0;
    logic        clear_i = 1'b0;
    logic        motor_done_i = 1'b0;
    logic        eject_ack_i = 1'b0;
    logic        motor_o;
    logic        eject_o;
    logic        busy_o;
    logic        fault_o;
    logic        dropped_o;
    logic [2:0]  coins_left_o;
    logic [15:0] sales_cnt_o;
    logic [15:0] nickels_out_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_sales   = 16'd0;
    logic [15:0] exp_nickels = 16'd0;

    vend_sequencer #(.PULSE_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .soda_i(soda_i), .change_i(change_i),
        .clear_i(clear_i), .motor_done_i(motor_done_i), .eject_ack_i(eject_ack_i),
        .motor_o(motor_o), .eject_o(eject_o), .busy_o(busy_o), .fault_o(fault_o),
        .dropped_o(dropped_o), .coins_left_o(coins_left_o),
        .sales_cnt_o(sales_cnt_o), .nickels_out_o(nickels_out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_cmp++; if ({motor_o, eject_o, busy_o, fault_o, dropped_o} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {motor_o, eject_o, busy_o, fault_o, dropped_o}); end
        n_cmp++; if (coins_left_o !== 3'd0) begin n_fail++; $display("FAIL reset_coins: got %0d want 0", coins_left_o); end
        n_cmp++; if ({sales_cnt_o, nickels_out_o} !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %h want 0", {sales_cnt_o, nickels_out_o}); end
        tick; tick;
        rst_ni = 1'b1;
        tick;
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_exact_change;
        change_i = 3'd0; soda_i = 1'b1;
        tick;
        soda_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({motor_o, eject_o, busy_o} !== 3'b101) begin n_fail++; $display("FAIL exact_vend_cycle%0d: got %b want 101", i, {motor_o, eject_o, busy_o}); end
            if (i == 2) motor_done_i = 1'b1;
            tick;
        end
        motor_done_i = 1'b0;
        if (CNT_EN) exp_sales = exp_sales + 16'd1;
        n_cmp++; if ({motor_o, eject_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL exact_done: got %b want 000", {motor_o, eject_o, busy_o}); end
        n_cmp++; if (sales_cnt_o !== exp_sales) begin n_fail++; $display("FAIL exact_sales: got %0d want %0d", sales_cnt_o, exp_sales); end
    endtask

    task automatic test_change4;
        change_i = 3'd4; soda_i = 1'b1;
        tick;
        soda_i = 1'b0;
        n_cmp++; if (coins_left_o !== 3'd4) begin n_fail++; $display("FAIL chg4_latch: got %0d want 4", coins_left_o); end
        motor_done_i = 1'b1;
        tick;
        motor_done_i = 1'b0;
        if (CNT_EN) exp_sales = exp_sales + 16'd1;
        for (int n = 4; n >= 1; n--) begin
            for (int p = 0; p < 4; p++) begin
                n_cmp++; if ({eject_o, motor_o} !== 2'b10 || coins_left_o !== 3'(n)) begin n_fail++; $display("FAIL chg4_pulse n%0d p%0d: got eject=%b motor=%b coins=%0d want 1 0 %0d", n, p, eject_o, motor_o, coins_left_o, n); end
                tick;
            end
            n_cmp++; if ({eject_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL chg4_wait n%0d: got %b want 01", n, {eject_o, busy_o}); end
            tick;
            eject_ack_i = 1'b1;
            tick;
            eject_ack_i = 1'b0;
            if (CNT_EN) exp_nickels = exp_nickels + 16'd1;
            n_cmp++; if (coins_left_o !== 3'(n - 1)) begin n_fail++; $display("FAIL chg4_step n%0d: got %0d want %0d", n, coins_left_o, n - 1); end
        end
        n_cmp++; if ({busy_o, eject_o, fault_o} !== 3'b000) begin n_fail++; $display("FAIL chg4_idle: got %b want 000", {busy_o, eject_o, fault_o}); end
        n_cmp++; if (nickels_out_o !== exp_nickels) begin n_fail++; $display("FAIL chg4_nickels: got %0d want %0d", nickels_out_o, exp_nickels); end
        n_cmp++; if (sales_cnt_o !== exp_sales) begin n_fail++; $display("FAIL chg4_sales: got %0d want %0d", sales_cnt_o, exp_sales); end
    endtask

    task automatic test_hopper_timeout;
        change_i = 3'd2; soda_i = 1'b1;
        tick;
        soda_i = 1'b0; motor_done_i = 1'b1;
        tick;
        motor_done_i = 1'b0;
        if (CNT_EN) exp_sales = exp_sales + 16'd1;
        repeat (4) tick;
        eject_ack_i = 1'b1;
        tick;
        eject_ack_i = 1'b0;
        if (CNT_EN) exp_nickels = exp_nickels + 16'd1;
        n_cmp++; if ({eject_o, coins_left_o} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL tmo_first_ack: got eject=%b coins=%0d want 1 1", eject_o, coins_left_o); end
        repeat (4) tick;
        repeat (9) tick;
        n_cmp++; if ({fault_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL tmo_before: got %b want 01", {fault_o, busy_o}); end
        tick;
        n_cmp++; if ({fault_o, busy_o, motor_o, eject_o} !== 4'b1100 || coins_left_o !== 3'd1) begin n_fail++; $display("FAIL tmo_fault: got %b coins=%0d want 1100 coins=1", {fault_o, busy_o, motor_o, eject_o}, coins_left_o); end
        eject_ack_i = 1'b1;
        tick;
        eject_ack_i = 1'b0;
        n_cmp++; if ({fault_o, coins_left_o} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL tmo_late_ack: got fault=%b coins=%0d want 1 1", fault_o, coins_left_o); end
        clear_i = 1'b1; soda_i = 1'b1; change_i = 3'd5;
        tick;
        clear_i = 1'b0; soda_i = 1'b0;
        n_cmp++; if ({fault_o, busy_o, dropped_o, motor_o} !== 4'b0010 || coins_left_o !== 3'd0) begin n_fail++; $display("FAIL tmo_clear: got %b coins=%0d want 0010 coins=0", {fault_o, busy_o, dropped_o, motor_o}, coins_left_o); end
        tick;
        n_cmp++; if ({dropped_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL tmo_after_clear: got %b want 00", {dropped_o, busy_o}); end
        n_cmp++; if (nickels_out_o !== exp_nickels) begin n_fail++; $display("FAIL tmo_nickels: got %0d want %0d", nickels_out_o, exp_nickels); end
    endtask

    task automatic test_vend_timeout_edge;
        change_i = 3'd0; soda_i = 1'b1;
        tick;
        soda_i = 1'b0;
        repeat (9) tick;
        motor_done_i = 1'b1;
        tick;
        motor_done_i = 1'b0;
        if (CNT_EN) exp_sales = exp_sales + 16'd1;
        n_cmp++; if ({fault_o, busy_o, motor_o} !== 3'b000) begin n_fail++; $display("FAIL edge_success: got %b want 000", {fault_o, busy_o, motor_o}); end
        change_i = 3'd0; soda_i = 1'b1;
        tick;
        soda_i = 1'b0;
        repeat (9) tick;
        n_cmp++; if ({fault_o, motor_o} !== 2'b01) begin n_fail++; $display("FAIL motor_tmo_before: got %b want 01", {fault_o, motor_o}); end
        tick;
        n_cmp++; if ({fault_o, motor_o, busy_o} !== 3'b101) begin n_fail++; $display("FAIL motor_tmo_fault: got %b want 101", {fault_o, motor_o, busy_o}); end
        clear_i = 1'b1;
        tick;
        clear_i = 1'b0;
        n_cmp++; if (sales_cnt_o !== exp_sales) begin n_fail++; $display("FAIL edge_sales: got %0d want %0d", sales_cnt_o, exp_sales); end
    endtask

    task automatic test_busy_drop;
        change_i = 3'd1; soda_i = 1'b1;
        tick;
        change_i = 3'd5;
        tick;
        soda_i = 1'b0;
        n_cmp++; if ({dropped_o, motor_o} !== 2'b11 || coins_left_o !== 3'd1) begin n_fail++; $display("FAIL drop_pulse: got %b coins=%0d want 11 coins=1", {dropped_o, motor_o}, coins_left_o); end
        tick;
        n_cmp++; if (dropped_o !== 1'b0) begin n_fail++; $display("FAIL drop_once: got %b want 0", dropped_o); end
        motor_done_i = 1'b1;
        tick;
        motor_done_i = 1'b0;
        if (CNT_EN) exp_sales = exp_sales + 16'd1;
        repeat (4) tick;
        eject_ack_i = 1'b1;
        tick;
        eject_ack_i = 1'b0;
        if (CNT_EN) exp_nickels = exp_nickels + 16'd1;
        tick; tick;
        n_cmp++; if ({motor_o, busy_o} !== 2'b00 || coins_left_o !== 3'd0) begin n_fail++; $display("FAIL drop_single_vend: got %b coins=%0d want 00 coins=0", {motor_o, busy_o}, coins_left_o); end
        n_cmp++; if (sales_cnt_o !== exp_sales) begin n_fail++; $display("FAIL drop_sales: got %0d want %0d", sales_cnt_o, exp_sales); end
    endtask

    task automatic test_early_ack;
        change_i = 3'd1; soda_i = 1'b1;
        tick;
        soda_i = 1'b0; motor_done_i = 1'b1;
        tick;
        motor_done_i = 1'b0; eject_ack_i = 1'b1;
        if (CNT_EN) exp_sales = exp_sales + 16'd1;
        for (int p = 0; p < 4; p++) begin
            n_cmp++; if ({eject_o, coins_left_o} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL early_pulse p%0d: got eject=%b coins=%0d want 1 1", p, eject_o, coins_left_o); end
            tick;
        end
        eject_ack_i = 1'b0;
        n_cmp++; if ({eject_o, busy_o, coins_left_o} !== {2'b01, 3'd1}) begin n_fail++; $display("FAIL early_wait: got %b coins=%0d want 01 coins=1", {eject_o, busy_o}, coins_left_o); end
        tick;
        eject_ack_i = 1'b1;
        tick;
        eject_ack_i = 1'b0;
        if (CNT_EN) exp_nickels = exp_nickels + 16'd1;
        n_cmp++; if ({busy_o, coins_left_o} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL early_done: got busy=%b coins=%0d want 0 0", busy_o, coins_left_o); end
        n_cmp++; if (nickels_out_o !== exp_nickels) begin n_fail++; $display("FAIL early_nickels: got %0d want %0d", nickels_out_o, exp_nickels); end
    endtask

    task automatic test_back_to_back;
        clear_i = 1'b1;
        tick;
        clear_i = 1'b0;
        n_cmp++; if ({fault_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL idle_clear: got %b want 00", {fault_o, busy_o}); end
        change_i = 3'd0; soda_i = 1'b1;
        tick;
        soda_i = 1'b0; motor_done_i = 1'b1;
        tick;
        motor_done_i = 1'b0; soda_i = 1'b1;
        if (CNT_EN) exp_sales = exp_sales + 16'd1;
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b want 0", busy_o); end
        tick;
        soda_i = 1'b0;
        n_cmp++; if ({motor_o, busy_o, dropped_o} !== 3'b110) begin n_fail++; $display("FAIL b2b_accept: got %b want 110", {motor_o, busy_o, dropped_o}); end
        motor_done_i = 1'b1;
        tick;
        motor_done_i = 1'b0;
        if (CNT_EN) exp_sales = exp_sales + 16'd1;
        n_cmp++; if (sales_cnt_o !== exp_sales) begin n_fail++; $display("FAIL b2b_sales: got %0d want %0d", sales_cnt_o, exp_sales); end
    endtask

    task automatic test_reset_mid_eject;
        change_i = 3'd3; soda_i = 1'b1;
        tick;
        soda_i = 1'b0; motor_done_i = 1'b1;
        tick;
        motor_done_i = 1'b0;
        tick;
        n_cmp++; if (eject_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %b want 1", eject_o); end
        #2 rst_ni = 1'b0;
        #1;
        exp_sales = 16'd0; exp_nickels = 16'd0;
        n_cmp++; if ({eject_o, motor_o, busy_o, coins_left_o} !== 6'd0) begin n_fail++; $display("FAIL rst_mid_async: got eject=%b motor=%b busy=%b coins=%0d want all 0", eject_o, motor_o, busy_o, coins_left_o); end
        n_cmp++; if ({sales_cnt_o, nickels_out_o} !== 32'd0) begin n_fail++; $display("FAIL rst_mid_counters: got %h want 0", {sales_cnt_o, nickels_out_o}); end
        #2 rst_ni = 1'b1;
        tick; tick;
        n_cmp++; if ({eject_o, motor_o, busy_o, coins_left_o} !== 6'd0) begin n_fail++; $display("FAIL rst_mid_idle: got eject=%b motor=%b busy=%b coins=%0d want all 0", eject_o, motor_o, busy_o, coins_left_o); end
    endtask

    initial begin
        test_reset;
        test_exact_change;
        test_change4;
        test_hopper_timeout;
        test_vend_timeout_edge;
        test_busy_drop;
        test_early_ack;
        test_back_to_back;
        test_reset_mid_eject;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
